// File: rtl/abacus_counter_reader.sv
// abacus_counter_reader
//
// Wishbone initiator that sweeps a contiguous, word-aligned range of profiler
// registers. Each word is fetched with one single-beat read, then forwarded
// with its address on a valid/ready output stream, so counter snapshots can be
// exported without CPU involvement.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               one-cycle sweep request, ignored while busy
//   cfg_use_default     1: sweep from ABACUS_BASE_ADDR, 0: from cfg_base_addr
//   cfg_base_addr       first address, bits [1:0] forced to 0
//   cfg_word_count      number of words to read (0..63)
//   abort               cancels a sweep; beats start, ack and m_ready
//   busy                sweep in progress
//   done                one-cycle pulse on normal end or timeout
//   timeout_err         sticky timeout flag, cleared by the next accepted start
//   wb_*                Wishbone initiator (reads only)
//   m_valid/m_ready     output stream handshake
//   m_data/m_addr       captured read data and its address
//   m_last              final beat of the sweep
//
// Stream handshake: a beat transfers on any rising edge where m_valid and
// m_ready are both 1. Once m_valid rises, m_data, m_addr and m_last hold
// stable and m_valid stays high until the transfer (or an abort/reset).
module abacus_counter_reader #(
  parameter int          TIMEOUT_CYCLES   = 16,
  parameter logic [31:0] ABACUS_BASE_ADDR = 32'hf0030000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cfg_use_default,
  input  logic [31:0] cfg_base_addr,
  input  logic [5:0]  cfg_word_count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [31:0] m_addr,
  output logic        m_last
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     addr;
  logic [5:0]      remaining;
  logic [TW-1:0]   tmo_cnt;

  // Decoded actions for the current cycle, consumed by the datapath.
  logic load;        // non-empty sweep accepted
  logic zero_start;  // empty sweep accepted: only a done pulse
  logic capture;     // ack received, latch the beat
  logic advance;     // beat accepted, move to the next word
  logic tmo_hit;     // read expired without ack
  logic finish;      // last beat accepted

  // Next-state and action decode. abort overrides everything else.
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    zero_start = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    tmo_hit    = 1'b0;
    finish     = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_word_count != 6'd0) begin
              load      = 1'b1;
              state_nxt = REQ;
            end else begin
              zero_start = 1'b1;
            end
          end
        end
        REQ: begin
          if (wb_ack) begin
            capture   = 1'b1;
            state_nxt = OUT;
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_hit   = 1'b1;
            state_nxt = IDLE;
          end
        end
        OUT: begin
          if (m_ready) begin
            if (m_last) begin
              finish    = 1'b1;
              state_nxt = IDLE;
            end else begin
              advance   = 1'b1;
              state_nxt = REQ;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= 32'd0;
      remaining   <= 6'd0;
      tmo_cnt     <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      m_data      <= 32'd0;
      m_addr      <= 32'd0;
      m_last      <= 1'b0;
    end else begin
      done <= zero_start | tmo_hit | finish;

      if (load | zero_start) begin
        timeout_err <= 1'b0;
      end else if (tmo_hit) begin
        timeout_err <= 1'b1;
      end

      if (load) begin
        addr      <= (cfg_use_default ? ABACUS_BASE_ADDR : cfg_base_addr) & 32'hFFFF_FFFC;
        remaining <= cfg_word_count;
        tmo_cnt   <= '0;
      end else if (advance) begin
        // Wraps naturally at 2^32.
        addr      <= addr + 32'd4;
        remaining <= remaining - 6'd1;
        tmo_cnt   <= '0;
      end else if (state == REQ) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (capture) begin
        m_data <= wb_dat_i;
        m_addr <= addr;
        m_last <= (remaining == 6'd1);
      end
    end
  end

  // Bus and stream controls decode straight from the state register, so an
  // asynchronous reset drops them immediately.
  assign busy     = (state != IDLE);
  assign wb_cyc   = (state == REQ);
  assign wb_stb   = (state == REQ);
  assign wb_we    = 1'b0;
  assign wb_adr   = addr;
  assign wb_dat_o = 32'd0;
  assign m_valid  = (state == OUT);

endmodule

// File: tb/tb_abacus_counter_reader.sv
// Directed bench for abacus_counter_reader. Inputs change on the falling edge,
// outputs are sampled on the falling edge; "cycle k" is the cycle after rising
// edge k-1, with the start accepted at edge 0.
module tb_abacus_counter_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cfg_use_default;
  logic [31:0] cfg_base_addr;
  logic [5:0]  cfg_word_count;
  logic        abort;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [31:0] m_addr;
  logic        m_last;

  // Responder model
  logic        resp_en;
  logic        ack_r;
  logic        ack_force;
  logic [31:0] dat_r;

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];
  logic [31:0] exp_a;

  localparam logic [31:0] XMASK = 32'h5A5A5A5A;

  abacus_counter_reader #(
    .TIMEOUT_CYCLES(16),
    .ABACUS_BASE_ADDR(32'hf0030000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cfg_use_default(cfg_use_default),
    .cfg_base_addr(cfg_base_addr),
    .cfg_word_count(cfg_word_count),
    .abort(abort),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err),
    .wb_cyc(wb_cyc),
    .wb_stb(wb_stb),
    .wb_we(wb_we),
    .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_addr(m_addr),
    .m_last(m_last)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need summary");
    $fatal(1, "watchdog expired");
  end

  // One-cycle-ack responder, returns address ^ 5A5A5A5A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
    end else begin
      ack_r <= resp_en & wb_cyc & wb_stb & ~ack_r;
      dat_r <= wb_adr ^ XMASK;
    end
  end
  assign wb_ack   = ack_r | ack_force;
  assign wb_dat_i = dat_r;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Present start for one rising edge (edge 0); returns just after it.
  task automatic do_start(input logic use_def, input logic [31:0] base, input logic [5:0] cnt);
    start           = 1'b1;
    cfg_use_default = use_def;
    cfg_base_addr   = base;
    cfg_word_count  = cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int valids;
    int cycs;
    vectors     = 0;
    miscompares = 0;
    rst             = 1'b1;
    start           = 1'b0;
    cfg_use_default = 1'b0;
    cfg_base_addr   = 32'd0;
    cfg_word_count  = 6'd0;
    abort           = 1'b0;
    m_ready         = 1'b1;
    resp_en         = 1'b1;
    ack_force       = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_cyc", wb_cyc, 0);
    check("rst_valid", m_valid, 0);
    check("rst_adr", wb_adr, 0);
    check("rst_done", done, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_we", wb_we, 0);
    rst = 1'b0;
    tick();

    // ---- normal sweep, 3 words from default base ----
    exp_q.push_back(32'hf0030000);
    exp_q.push_back(32'hf0030004);
    exp_q.push_back(32'hf0030008);
    do_start(1'b1, 32'h12345678, 6'd3);
    for (int c = 1; c <= 11; c++) begin
      tick();
      check("n_busy", busy, 32'(c < 10));
      check("n_cyc", wb_cyc, 32'((c % 3 != 0) && (c < 10)));
      check("n_valid", m_valid, 32'((c % 3 == 0) && (c < 10)));
      check("n_done", done, 32'(c == 10));
      if (wb_cyc) check("n_adr", wb_adr, 32'hf0030000 + 32'(4 * ((c - 1) / 3)));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("n_extra_beat", 1, 0);
        end else begin
          exp_a = exp_q.pop_front();
          check("n_maddr", m_addr, exp_a);
          check("n_mdata", m_data, exp_a ^ XMASK);
          check("n_mlast", m_last, 32'(c == 9));
        end
      end
    end
    check("n_beats_left", exp_q.size(), 0);
    check("n_terr", timeout_err, 0);

    // ---- backpressure on beat 1 ----
    m_ready = 1'b0;
    do_start(1'b0, 32'h00001000, 6'd2);
    tick(); tick();                       // cycles 1,2
    for (int c = 3; c <= 8; c++) begin
      tick();
      check("bp_valid", m_valid, 1);
      check("bp_maddr", m_addr, 32'h00001000);
      check("bp_mdata", m_data, 32'h00001000 ^ XMASK);
      check("bp_cyc", wb_cyc, 0);
    end
    m_ready = 1'b1;                       // sampled at edge 8
    tick();                               // cycle 9
    check("bp_resume_cyc", wb_cyc, 1);
    check("bp_resume_adr", wb_adr, 32'h00001004);
    tick(); tick();                       // cycle 11
    check("bp_b2_valid", m_valid, 1);
    check("bp_b2_last", m_last, 1);
    check("bp_b2_data", m_data, 32'h00001004 ^ XMASK);
    tick();                               // cycle 12
    check("bp_done", done, 1);
    check("bp_busy", busy, 0);

    // ---- timeout ----
    resp_en = 1'b0;
    do_start(1'b1, 32'd0, 6'd1);
    valids = 0;
    cycs   = 0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (wb_cyc) cycs++;
      if (m_valid) valids++;
      if (c == 16) check("to_cyc16", wb_cyc, 1);
    end
    check("to_cyc_count", cycs, 16);
    check("to_no_valid", valids, 0);
    check("to_done", done, 1);
    check("to_terr", timeout_err, 1);
    check("to_busy", busy, 0);
    check("to_cyc17", wb_cyc, 0);
    tick();
    check("to_terr_sticky", timeout_err, 1);
    resp_en = 1'b1;
    do_start(1'b1, 32'd0, 6'd1);
    tick();
    check("to_terr_clear", timeout_err, 0);
    begin
      int seen;
      seen = 0;
      for (int c = 2; c <= 10 && seen == 0; c++) begin
        tick();
        if (done) seen = 1;
      end
      check("to_recover_done", seen, 1);
    end

    // ---- zero count ----
    do_start(1'b1, 32'd0, 6'd0);
    tick();
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    cycs = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      if (wb_cyc | busy) cycs++;
    end
    check("z_no_cyc", cycs, 0);
    check("z_done_once", done, 0);

    // ---- wrap and alignment ----
    do_start(1'b0, 32'hFFFFFFFE, 6'd2);
    tick();
    check("w_adr1", wb_adr, 32'hFFFFFFFC);
    tick(); tick();                       // cycle 3
    check("w_maddr1", m_addr, 32'hFFFFFFFC);
    check("w_mdata1", m_data, 32'hA5A5A5A6);
    check("w_mlast1", m_last, 0);
    tick();                               // cycle 4
    check("w_adr2", wb_adr, 32'h00000000);
    check("w_cyc2", wb_cyc, 1);
    tick(); tick();                       // cycle 6
    check("w_maddr2", m_addr, 32'h00000000);
    check("w_mdata2", m_data, 32'h5A5A5A5A);
    check("w_mlast2", m_last, 1);
    tick();
    check("w_done", done, 1);

    // ---- abort in REQ together with ack ----
    resp_en = 1'b0;
    do_start(1'b1, 32'd0, 6'd1);
    tick();                               // cycle 1, REQ
    check("ab_req", wb_cyc, 1);
    abort     = 1'b1;
    ack_force = 1'b1;                     // both sampled at edge 1
    tick();                               // cycle 2
    abort     = 1'b0;
    ack_force = 1'b0;
    check("ab_cyc", wb_cyc, 0);
    check("ab_busy", busy, 0);
    check("ab_valid", m_valid, 0);
    check("ab_done", done, 0);
    tick();
    check("ab_done2", done, 0);
    check("ab_valid2", m_valid, 0);
    check("ab_terr", timeout_err, 0);
    resp_en = 1'b1;

    // ---- async reset while in OUT ----
    m_ready = 1'b0;
    do_start(1'b1, 32'd0, 6'd1);
    tick(); tick(); tick();               // cycle 3
    check("rs_out_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    check("rs_valid", m_valid, 0);
    check("rs_cyc", wb_cyc, 0);
    check("rs_busy", busy, 0);
    check("rs_mdata", m_data, 0);
    tick();
    rst     = 1'b0;
    m_ready = 1'b1;
    tick();
    check("rs_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/abacus_counter_reader.md
# abacus_counter_reader

Wishbone initiator that sweeps a contiguous, word-aligned range of profiler register addresses. It issues one single-beat read per word and forwards each returned value, tagged with its address, on a valid/ready output stream. It sits between a debug/export path (UART dumper, trace buffer) and the profiler's Wishbone responder, so counter snapshots are taken without CPU involvement.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: max cycles one read may wait for wb_ack before the sweep is aborted with error (≥2).
- ABACUS_BASE_ADDR, 32'hf0030000: default sweep base, used when cfg_use_default=1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep; ignored while busy=1.
- cfg_use_default  in  1  1: sweep from ABACUS_BASE_ADDR; 0: sweep from cfg_base_addr. Sampled with start.
- cfg_base_addr  in  32  first address; bits [1:0] ignored (forced 0). Sampled with start.
- cfg_word_count  in  6  words to read, 0..63. Sampled with start.
- abort  in  1  cancels any sweep in progress.
- busy  out  1  high from the cycle after an accepted start until the sweep ends.
- done  out  1  one-cycle pulse when a sweep ends normally or by timeout.
- timeout_err  out  1  sticky; set on timeout, cleared by the next accepted start.
- wb_cyc, wb_stb  out  1  bus cycle and strobe, always equal.
- wb_we  out  1  constant 0; reads only.
- wb_adr  out  32  current read address.
- wb_dat_o  out  32  constant 0.
- wb_dat_i  in  32  read data, valid when wb_ack=1.
- wb_ack  in  1  responder acknowledge.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  32  captured read data.
- m_addr  out  32  address the data came from.
- m_last  out  1  high on the final beat of a sweep.

## Operation
- Reset values: all outputs 0; state IDLE; internal address and count registers 0.
- State IDLE:
  - start with count≠0: latch address and remaining=count, clear timeout_err, go REQ.
  - start with count=0: pulse done next cycle, stay IDLE, never assert wb_cyc.
- State REQ:
  - wb_cyc=wb_stb=1, wb_adr=current address; the timeout counter runs.
  - On wb_ack=1: capture wb_dat_i into m_data and wb_adr into m_addr, set m_last=(remaining==1), go OUT.
  - If TIMEOUT_CYCLES cycles elapse with no ack: drop wb_cyc/wb_stb, set timeout_err, pulse done, go IDLE. The word is not emitted.
- State OUT:
  - m_valid=1; m_data, m_addr and m_last hold stable until accepted.
  - On m_valid&m_ready: if m_last, pulse done and go IDLE. Otherwise address+=4, remaining-=1, go REQ.
- Address arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 32'h0.
- abort, in any state:
  - Next cycle: wb_cyc/wb_stb/m_valid=0, state IDLE, busy=0.
  - No done pulse; timeout_err unchanged.
  - abort takes priority over start, ack and m_ready in the same cycle.
- An ack arriving while in IDLE or OUT is ignored.
- Asynchronous reset mid-sweep: outputs return to reset values immediately; there is no resumption.

## Timing
- start is accepted at edge 0. busy=1 and wb_cyc=1 from cycle 1.
- The responder acks one cycle after strobe, so ack is seen in cycle 2 and m_valid=1 from cycle 3.
- With m_ready=1, the next wb_cyc rises in cycle 4: 3 cycles per word, so an N-word sweep ends with done in cycle 3N+1.
- wb_cyc is low for at least one cycle between consecutive reads. This is required by the responder's ack<=cyc&stb&~ack rule.
- wb_cyc/wb_stb fall in the cycle after ack is sampled.
- Timeout: wb_cyc high for exactly TIMEOUT_CYCLES cycles; done and timeout_err rise in the following cycle.
- busy falls in the same cycle done pulses.

## Test plan
- Normal sweep: cfg_use_default=1 (ABACUS_BASE_ADDR=32'hf0030000), cfg_word_count=3, 1-cycle-ack responder returning data=address^32'h5A5A5A5A, m_ready=1 -> beats at addresses f0030000/04/08, each m_data=address^32'h5A5A5A5A, m_last only on beat 3, done in cycle 10.
- Backpressure: hold m_ready=0 for 5 cycles on beat 1 -> m_valid, m_data and m_addr stable, wb_cyc stays 0, sweep resumes 1 cycle after m_ready=1.
- Timeout: responder never acks, TIMEOUT_CYCLES=16 -> wb_cyc high 16 cycles, then done=1, timeout_err=1, busy=0, no m_valid. A following start clears timeout_err.
- Zero count: start with cfg_word_count=0 -> done pulse in cycle 1, wb_cyc never asserts, busy stays 0.
- Wrap and alignment: cfg_base_addr=32'hFFFFFFFE, count=2 -> reads at FFFFFFFC then 00000000.
- Abort/reset: abort asserted in REQ together with wb_ack -> no beat emitted, no done, IDLE next cycle. rst asserted in OUT -> m_valid=0 and wb_cyc=0 before the next clock edge.
